lsu_rmw: RTL and testbench
==========================

Name: lsu_rmw

Overview:
- Load/store unit between the CPU datapath and the word-addressed data memory (sync write, combinational read).
- Converts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses.
- Loads: extracts and sign/zero-extends the selected byte/half.
- Sub-word stores: two-step read-modify-write.
- Rejects misaligned, illegal-size and out-of-range requests with an error response.

Parameters:
- ADDRESS_WIDTH, 8, word-address width of the data memory (2**ADDRESS_WIDTH words).
- DATA_WIDTH, 32, data word width; only 32 supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  request rejected (valid with resp_valid only).
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_we  out  1  data memory write enable.
- mem_a  out  ADDRESS_WIDTH  data memory word address.
- mem_wd  out  32  data memory write data.
- mem_rd  in  32  data memory read data (combinational).

Behaviour:
- Reset values:
  - State IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - Held request registers=0.
  - mem_we=0 immediately on rst_n low; mem_we is decoded from state, so the reset is asynchronous.
- Accept: req_valid && req_ready on a rising edge. Address, funct3, we and wdata are registered into holding registers.
- Decode at accept:
  - Legal loads: funct3 000, 001, 010, 100, 101.
  - Legal stores: 000, 001, 010.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: addr[31:ADDRESS_WIDTH+2] != 0.
  - Any illegal/misaligned/out-of-range request goes to ERR.
- States:
  - IDLE: ready=1.
    - Error -> ERR.
    - Load -> LOAD.
    - SW -> WRITE.
    - SB/SH -> READ.
  - LOAD: mem_a=held addr[ADDRESS_WIDTH+1:2]. Select lane by addr[1:0] and extend per funct3 into resp_rdata register. -> IDLE.
  - READ: capture mem_rd into merge register. -> WRITE.
  - WRITE: mem_we=1 for exactly this cycle. mem_wd is one of:
    - SW: held wdata.
    - SH: merge word with bits [16*addr[1]+:16] replaced by wdata[15:0].
    - SB: merge word with bits [8*addr[1:0]+:8] replaced by wdata[7:0].
    - Then -> IDLE.
  - ERR: -> IDLE, no memory access.
- Response: resp_valid is registered, asserted the cycle after leaving LOAD/WRITE/ERR. resp_err=1 only for ERR completions.
- Latency from accept edge T:
  - Load: resp at T+2.
  - SW: mem_we at T+1, resp at T+2.
  - SB/SH: mem_we at T+2, resp at T+3.
  - Error: resp at T+2.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high (state is IDLE). A load after a store to the same word returns the new data.
- mem_a = held word address in all states. mem_wd=0 and mem_we=0 outside WRITE.
- req_* inputs are ignored when not accepted. resp_rdata holds its value until the next completion.
- Reset mid-operation: the transaction is abandoned and no write occurs (including from READ). No resp_valid is produced. ready=1 on the first edge after release.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - state enum lsu_state_t {IDLE, LOAD, READ, WRITE, ERR}.
- Sub-module lsu_align (combinational): lane select + sign/zero extension for loads, and byte/half merge for stores. The FSM and registers stay in lsu_rmw.

Test Plan:
- Word 4 = 0xDEADBEEF. LB 0x13 -> resp_rdata 0xFFFFFFDE at T+2. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
- Word 4 = 0xDEADBEEF. SB 0x11 wdata 0x123456AA -> mem_we high only at T+2 with mem_a=4, mem_wd 0xDEADAAEF. resp_valid at T+3, resp_err=0.
- SH 0x13 / LW 0x12 / funct3 011 load / SH funct3 100 store -> resp_valid+resp_err at T+2, resp_rdata=0, mem_we never asserted.
- ADDRESS_WIDTH=8, LW 0x400 -> resp_err=1. LW 0x3FC -> word 255 data, no error.
- SW 0x20 wdata 0x12345678, then LW 0x20 issued in the SW resp_valid cycle -> accepted immediately, resp_rdata 0x12345678 two cycles later.
- SB 0x11 started, rst_n pulled low during READ -> mem_we stays 0, word 4 unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and the request legality check applied when a request is accepted.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    WRITE,
    ERR
  } lsu_state_t;

  // True when funct3 is not a legal size for the direction, or the byte
  // offset breaks natural alignment for that size.
  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic legal;
    logic misaligned;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
                 ((f3 == F3_W) && (off != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_rd,
  input  logic [XLEN-1:0] i_merge,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic [XLEN-1:0] o_store_data
);

  logic [XLEN-1:0] w_lane;

  // NOTE: every output of a combinational block gets a value on every path
  // (default first, then overrides) so no latch is inferred.
  always_comb begin
    w_lane = i_rd >> {i_offset, 3'b000};
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU:   o_load_data = {24'b0, w_lane[7:0]};
      F3_HU:   o_load_data = {16'b0, w_lane[15:0]};
      default: o_load_data = w_lane;
    endcase
  end

  always_comb begin
    o_store_data = i_merge;
    case (i_funct3)
      F3_B:    o_store_data[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_store_data[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_store_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between the CPU and a word-addressed data memory. Sub-word
// stores are done as a read cycle followed by a merged write cycle.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  lsu_state_t                r_state;
  logic [ADDRESS_WIDTH+1:0]  r_addr;
  logic [2:0]                r_funct3;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_merge;
  logic                      r_resp_valid;
  logic                      r_resp_err;
  logic [DATA_WIDTH-1:0]     r_resp_rdata;

  logic                      w_out_of_range;
  logic                      w_req_bad;
  logic [DATA_WIDTH-1:0]     w_load_data;
  logic [DATA_WIDTH-1:0]     w_store_data;

  assign w_out_of_range = |req_addr[31:ADDRESS_WIDTH+2];
  assign w_req_bad      = w_out_of_range || req_bad(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_offset     (r_addr[1:0]),
    .i_rd         (mem_rd),
    .i_merge      (r_merge),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  // Memory strobes decode straight from the state register, so an async
  // reset drops mem_we immediately and an abandoned store never writes.
  assign req_ready  = (r_state == IDLE);
  assign mem_we     = (r_state == WRITE);
  assign mem_a      = r_addr[ADDRESS_WIDTH+1:2];
  assign mem_wd     = (r_state == WRITE) ? w_store_data : '0;

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_merge      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr[ADDRESS_WIDTH+1:0];
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            if (w_req_bad)               r_state <= ERR;
            else if (!req_we)            r_state <= LOAD;
            else if (req_funct3 == F3_W) r_state <= WRITE;
            else                         r_state <= READ;
          end
        end
        LOAD: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_state      <= IDLE;
        end
        READ: begin
          r_merge <= mem_rd;
          r_state <= WRITE;
        end
        WRITE: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_state      <= IDLE;
        end
        ERR: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: a behavioural data memory, one task per
// scenario, expected values worked out by hand from the intended behaviour.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [7:0]  mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int total = 0;
  int bad   = 0;

  lsu_rmw #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory: sync write, combinational read, plus a backdoor preload port.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = 8'd0;
  logic [31:0] pl_d = 32'd0;
  assign mem_rd = mem[mem_a];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_a] <= mem_wd;
    else if (pl_en) mem[pl_a]  <= pl_d;
  end

  // Per-transaction observations; k counts negedges after the accept edge,
  // so k matches the edge index T+k at which a value is visible.
  int          t_we_n, t_we_k, t_resp_k;
  logic [7:0]  t_wa;
  logic [31:0] t_wd, t_rdata;
  logic        t_err;

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b1; req_funct3 = 3'b011;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    t_we_n = 0; t_we_k = 0; t_resp_k = 0; t_wa = 0; t_wd = 0; t_rdata = 0; t_err = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_we) begin t_we_n++; t_we_k = k; t_wa = mem_a; t_wd = mem_wd; end
      if (resp_valid) begin
        t_resp_k = k; t_err = resp_err; t_rdata = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_a !== 8'h0 || mem_wd !== 32'h0) begin bad++; $display("FAIL reset_mem_bus got a=%h wd=%h exp 0/0", mem_a, mem_wd); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads;
    logic [2:0]  f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad   [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] expd [5] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD,
                              32'h0000_BEEF, 32'hDEAD_BEEF};
    poke(8'd4, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, f3[i], ad[i], 32'h0);
      total++; if (t_resp_k != 2) begin bad++; $display("FAIL load%0d_latency got=%0d exp=2", i, t_resp_k); end
      total++; if (t_rdata !== expd[i] || t_err !== 1'b0) begin bad++; $display("FAIL load%0d_data got=%h err=%b exp=%h err=0", i, t_rdata, t_err, expd[i]); end
      total++; if (t_we_n != 0) begin bad++; $display("FAIL load%0d_no_write got=%0d writes exp=0", i, t_we_n); end
    end
  endtask

  task automatic test_sub_store;
    poke(8'd4, 32'hDEAD_BEEF);
    run_txn(1'b1, 3'b000, 32'h11, 32'h1234_56AA);
    total++; if (t_we_n != 1 || t_we_k != 2) begin bad++; $display("FAIL sb_we_timing got n=%0d k=%0d exp n=1 k=2", t_we_n, t_we_k); end
    total++; if (t_wa !== 8'd4 || t_wd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL sb_write got a=%h wd=%h exp a=04 wd=deadaaef", t_wa, t_wd); end
    total++; if (t_resp_k != 3 || t_err !== 1'b0 || t_rdata !== 32'h0) begin bad++; $display("FAIL sb_resp got k=%0d err=%b rd=%h exp k=3 err=0 rd=0", t_resp_k, t_err, t_rdata); end
    total++; if (mem[4] !== 32'hDEAD_AAEF) begin bad++; $display("FAIL sb_mem got=%h exp=deadaaef", mem[4]); end
    poke(8'd5, 32'h1122_3344);
    run_txn(1'b1, 3'b001, 32'h16, 32'hCAFE_5678);
    total++; if (t_we_k != 2 || t_resp_k != 3) begin bad++; $display("FAIL sh_timing got we_k=%0d resp_k=%0d exp 2/3", t_we_k, t_resp_k); end
    total++; if (mem[5] !== 32'h5678_3344) begin bad++; $display("FAIL sh_mem got=%h exp=56783344", mem[5]); end
  endtask

  task automatic test_errors;
    logic        we [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] ad [5] = '{32'h13, 32'h12, 32'h10, 32'h10, 32'h400};
    poke(8'd4, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, 3'b010, 32'h10, 32'h0);
      run_txn(we[i], f3[i], ad[i], 32'hA5A5_A5A5);
      total++; if (t_resp_k != 2 || t_err !== 1'b1) begin bad++; $display("FAIL err%0d_resp got k=%0d err=%b exp k=2 err=1", i, t_resp_k, t_err); end
      total++; if (t_rdata !== 32'h0 || t_we_n != 0) begin bad++; $display("FAIL err%0d_side got rd=%h writes=%0d exp rd=0 writes=0", i, t_rdata, t_we_n); end
    end
    total++; if (mem[4] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL err_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_range;
    poke(8'd255, 32'h0BAD_F00D);
    run_txn(1'b0, 3'b010, 32'h3FC, 32'h0);
    total++; if (t_resp_k != 2 || t_err !== 1'b0 || t_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL top_word got k=%0d err=%b rd=%h exp k=2 err=0 rd=0badf00d", t_resp_k, t_err, t_rdata); end
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 3'b010, 32'h20, 32'h1234_5678);
    total++; if (t_we_n != 1 || t_we_k != 1 || t_wa !== 8'd8 || t_wd !== 32'h1234_5678) begin bad++; $display("FAIL sw_write got n=%0d k=%0d a=%h wd=%h exp 1/1/08/12345678", t_we_n, t_we_k, t_wa, t_wd); end
    total++; if (t_resp_k != 2 || t_err !== 1'b0) begin bad++; $display("FAIL sw_resp got k=%0d err=%b exp k=2 err=0", t_resp_k, t_err); end
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_ready got ready=%b valid=%b exp 1/1", req_ready, resp_valid); end
    run_txn(1'b0, 3'b010, 32'h20, 32'h0);
    total++; if (t_resp_k != 2 || t_rdata !== 32'h1234_5678) begin bad++; $display("FAIL b2b_load got k=%0d rd=%h exp k=2 rd=12345678", t_resp_k, t_rdata); end
  endtask

  task automatic test_reset_mid;
    int seen_we;
    int seen_resp;
    seen_we = 0; seen_resp = 0;
    poke(8'd4, 32'hDEAD_BEEF);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h1234_56AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_now got we=%b ready=%b exp 0/1", mem_we, req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_we) seen_we++;
      if (resp_valid) seen_resp++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (mem_we) seen_we++;
      if (resp_valid) seen_resp++;
      if (k == 0) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
      end
    end
    @(negedge clk);
    total++; if (seen_we != 0 || seen_resp != 0) begin bad++; $display("FAIL mid_quiet got we=%0d resp=%0d exp 0/0", seen_we, seen_resp); end
    total++; if (mem[4] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_mem got=%h exp=deadbeef", mem[4]); end
    run_txn(1'b0, 3'b010, 32'h10, 32'h0);
    total++; if (t_resp_k != 2 || t_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_reload got k=%0d rd=%h exp k=2 rd=deadbeef", t_resp_k, t_rdata); end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_sub_store;
    test_errors;
    test_range;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
